// File: rtl/dmem_pkg.sv
// Shared data-memory definitions: access size encoding, arbiter FSM states, request bundle.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Used by the data-memory arbiter, the memory itself and the load/store unit.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    // Size code with no legal meaning; any access carrying it is rejected.
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ARB   = 2'b00,
        LOCK1 = 2'b01,
        FORCE = 2'b10
    } arb_state_e;

    // One requester's request fields, bundled for muxing onto the memory.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Number of bytes touched by an access of the given size.
    // The illegal code maps to 4 so that range arithmetic stays defined;
    // such accesses are flagged as errors independently.
    function automatic logic [2:0] size_bytes(input mem_size_e sz);
        case (sz)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            SZ_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Legality check for one data-memory access: size code, alignment and range.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated on whatever request is currently granted.
// Ports:
//   size  in  2   access size code (byte/half/word/illegal)
//   addr  in  32  byte address
//   err   out 1   access must be rejected
module dmem_access_check
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    output logic        err
);

    logic        bad_size;
    logic        misaligned;
    logic        out_of_range;
    logic [32:0] end_addr;

    always_comb begin
        bad_size   = (size == SZ_ILLEGAL);
        misaligned = ((size == SZ_HALF) && addr[0]) ||
                     ((size == SZ_WORD) && (addr[1:0] != 2'b00));
        // One extra bit so an address near 2^32 cannot wrap back into range.
        end_addr     = {1'b0, addr} + {30'd0, size_bytes(mem_size_e'(size))};
        out_of_range = (end_addr > 33'(MEM_BYTES));
        err          = bad_size | misaligned | out_of_range;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter onto a single-port data memory, with port-1 lock and access checking.
// Latency: grant combinational in the request cycle; response (registered) exactly one cycle later.
// Backpressure: valid/ready; only the granted port sees ready, the loser holds its request.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   mX_req_valid/ready         request handshake (ready = combinational grant)
//   mX_req_we/size/addr/wdata  request fields; wdata LSB-aligned
//   m1_lock                    port 1 asks to keep the grant across back-to-back requests
//   mX_resp_valid/rdata/err    one-cycle response; rdata sign-extended for loads, else 0
//   mem_write/size/addr/wdata  memory drive, muxed from the granted port
//   mem_rdata                  asynchronous, LSB-aligned read data from the memory
//   perf_mX_stall              (DMEM_ARB_PERF_EN only) saturating stall-cycle counters
// Build option: define DMEM_ARB_PERF_EN to add the stall counters.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256,
    parameter int unsigned LOCK_MAX  = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic        m0_req_we,
    input  logic [1:0]  m0_req_size,
    input  logic [31:0] m0_req_addr,
    input  logic [31:0] m0_req_wdata,
    output logic        m0_resp_valid,
    output logic [31:0] m0_resp_rdata,
    output logic        m0_resp_err,

    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic        m1_req_we,
    input  logic [1:0]  m1_req_size,
    input  logic [31:0] m1_req_addr,
    input  logic [31:0] m1_req_wdata,
    input  logic        m1_lock,
    output logic        m1_resp_valid,
    output logic [31:0] m1_resp_rdata,
    output logic        m1_resp_err,

    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_m0_stall,
    output logic [31:0] perf_m1_stall
`endif
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic [CNT_W-1:0] lock_cnt_q;
    logic [CNT_W-1:0] lock_cnt_d;
    logic             last_grant_q;   // 1 = port 1 was granted most recently

    logic             gnt0;
    logic             gnt1;
    logic             gnt_any;
    req_t             req0;
    req_t             req1;
    req_t             gnt_req;
    logic             acc_err;
    logic [31:0]      load_dat;

    logic             resp_vld_q;
    logic             resp_port_q;    // which port the pending response belongs to
    logic             resp_err_q;
    logic [31:0]      resp_rdata_q;

    assign req0 = '{we: m0_req_we, size: m0_req_size, addr: m0_req_addr, wdata: m0_req_wdata};
    assign req1 = '{we: m1_req_we, size: m1_req_size, addr: m1_req_addr, wdata: m1_req_wdata};

    // Arbitration and lock FSM next-state.
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;

        case (state_q)
            ARB: begin
                if (m0_req_valid && m1_req_valid) begin
                    gnt0 = last_grant_q;
                    gnt1 = ~last_grant_q;
                end else begin
                    gnt0 = m0_req_valid;
                    gnt1 = m1_req_valid;
                end
                // The entry grant already counts towards the lock budget.
                if (gnt1 && m1_lock) begin
                    lock_cnt_d = CNT_W'(1);
                    state_d    = (LOCK_MAX <= 1) ? FORCE : LOCK1;
                end
            end

            LOCK1: begin
                gnt1 = m1_req_valid;
                gnt0 = m0_req_valid & ~m1_req_valid;
                if (!m1_req_valid || !m1_lock) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                    if (lock_cnt_d == CNT_W'(LOCK_MAX)) begin
                        state_d = FORCE;
                    end
                end
            end

            FORCE: begin
                // Port 1 masked for one cycle so port 0 cannot starve.
                gnt0       = m0_req_valid;
                state_d    = ARB;
                lock_cnt_d = '0;
            end

            default: begin
                state_d    = ARB;
                lock_cnt_d = '0;
            end
        endcase
    end

    assign gnt_any = gnt0 | gnt1;
    assign gnt_req = gnt1 ? req1 : req0;

    dmem_access_check #(
        .MEM_BYTES (MEM_BYTES)
    ) u_check (
        .size (gnt_req.size),
        .addr (gnt_req.addr),
        .err  (acc_err)
    );

    // Memory returns the addressed bytes LSB-aligned; widen by the access size.
    always_comb begin
        case (gnt_req.size)
            SZ_BYTE: load_dat = {{24{mem_rdata[7]}},  mem_rdata[7:0]};
            SZ_HALF: load_dat = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            default: load_dat = mem_rdata;
        endcase
    end

    assign m0_req_ready = gnt0;
    assign m1_req_ready = gnt1;

    // The write lands on the same edge that completes the handshake; reset
    // in that cycle must not let it through.
    assign mem_write = gnt_any & gnt_req.we & ~acc_err & ~rst;
    assign mem_size  = gnt_req.size;
    assign mem_addr  = gnt_req.addr;
    assign mem_wdata = gnt_req.wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB;
            lock_cnt_q   <= '0;
            last_grant_q <= 1'b1;
            resp_vld_q   <= 1'b0;
            resp_port_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            if (gnt_any) begin
                last_grant_q <= gnt1;
            end
            resp_vld_q   <= gnt_any;
            resp_port_q  <= gnt1;
            resp_err_q   <= gnt_any & acc_err;
            resp_rdata_q <= (gnt_any && !gnt_req.we && !acc_err) ? load_dat : 32'd0;
        end
    end

    assign m0_resp_valid = resp_vld_q & ~resp_port_q;
    assign m1_resp_valid = resp_vld_q &  resp_port_q;
    assign m0_resp_err   = m0_resp_valid & resp_err_q;
    assign m1_resp_err   = m1_resp_valid & resp_err_q;
    assign m0_resp_rdata = m0_resp_valid ? resp_rdata_q : 32'd0;
    assign m1_resp_rdata = m1_resp_valid ? resp_rdata_q : 32'd0;

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_m0_stall <= '0;
            perf_m1_stall <= '0;
        end else begin
            if (m0_req_valid && !gnt0 && (perf_m0_stall != 32'hFFFF_FFFF)) begin
                perf_m0_stall <= perf_m0_stall + 32'd1;
            end
            if (m1_req_valid && !gnt1 && (perf_m1_stall != 32'hFFFF_FFFF)) begin
                perf_m1_stall <= perf_m1_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: byte memory model, reference memory and per-port response scoreboards.
// Latency: n/a.
// Backpressure: requests held until ready, bounded by a cycle budget.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        m0_req_valid, m0_req_ready, m0_req_we;
    logic [1:0]  m0_req_size;
    logic [31:0] m0_req_addr, m0_req_wdata;
    logic        m0_resp_valid, m0_resp_err;
    logic [31:0] m0_resp_rdata;
    logic        m1_req_valid, m1_req_ready, m1_req_we, m1_lock;
    logic [1:0]  m1_req_size;
    logic [31:0] m1_req_addr, m1_req_wdata;
    logic        m1_resp_valid, m1_resp_err;
    logic [31:0] m1_resp_rdata;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_m0_stall, perf_m1_stall;
`endif

    dmem_arbiter #(.MEM_BYTES(256), .LOCK_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
        .m0_req_size(m0_req_size), .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
        .m0_resp_valid(m0_resp_valid), .m0_resp_rdata(m0_resp_rdata), .m0_resp_err(m0_resp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
        .m1_req_size(m1_req_size), .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
        .m1_lock(m1_lock),
        .m1_resp_valid(m1_resp_valid), .m1_resp_rdata(m1_resp_rdata), .m1_resp_err(m1_resp_err),
        .mem_write(mem_write), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .perf_m0_stall(perf_m0_stall), .perf_m1_stall(perf_m1_stall)
`endif
    );

    // ---------------- memory model (what the DUT actually writes) ----------------
    logic [7:0] mem [0:255];
    logic [7:0] ma;
    int         wr_cnt = 0;
    assign ma        = mem_addr[7:0];
    assign mem_rdata = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};

    always @(posedge clk) begin
        if (mem_write) begin
            wr_cnt <= wr_cnt + 1;
            mem[ma] <= mem_wdata[7:0];
            if (mem_size != 2'b00) mem[ma + 8'd1] <= mem_wdata[15:8];
            if (mem_size == 2'b10) begin
                mem[ma + 8'd2] <= mem_wdata[23:16];
                mem[ma + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic [7:0] ref_mem [0:255];
    exp_t       q0[$];
    exp_t       q1[$];
    int         glog[$];          // port number of each accepted request, in order
    int         n_resp0 = 0, n_resp1 = 0;
    logic [31:0] last_rdata0, last_rdata1;
    logic        last_err0, last_err1;

    function automatic logic exp_err(input logic [1:0] sz, input logic [31:0] a);
        logic [32:0] nb;
        nb = (sz == 2'b00) ? 33'd1 : (sz == 2'b01) ? 33'd2 : 33'd4;
        if (sz == 2'b11) return 1'b1;
        if (sz == 2'b01 && a[0]) return 1'b1;
        if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b1;
        if (({1'b0, a} + nb) > 33'd256) return 1'b1;
        return 1'b0;
    endfunction

    task automatic predict(input logic we, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, output exp_t e);
        logic [7:0] b0, b1, b2, b3;
        e.err   = exp_err(sz, a);
        e.rdata = 32'd0;
        e.cyc   = cyc;
        if (!e.err) begin
            if (we) begin
                ref_mem[a[7:0]] = wd[7:0];
                if (sz != 2'b00) ref_mem[a[7:0] + 8'd1] = wd[15:8];
                if (sz == 2'b10) begin
                    ref_mem[a[7:0] + 8'd2] = wd[23:16];
                    ref_mem[a[7:0] + 8'd3] = wd[31:24];
                end
            end else begin
                b0 = ref_mem[a[7:0]];
                b1 = ref_mem[a[7:0] + 8'd1];
                b2 = ref_mem[a[7:0] + 8'd2];
                b3 = ref_mem[a[7:0] + 8'd3];
                if (sz == 2'b00)      e.rdata = {{24{b0[7]}}, b0};
                else if (sz == 2'b01) e.rdata = {{16{b1[7]}}, b1, b0};
                else                  e.rdata = {b3, b2, b1, b0};
            end
        end
    endtask

    // Responses are compared, then new acceptances are predicted, once per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (m0_resp_valid) begin
                n_resp0++;
                last_rdata0 = m0_resp_rdata;
                last_err0   = m0_resp_err;
                check("m0_resp_expected", 32'(q0.size() > 0), 32'd1);
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    check("m0_err", 32'(m0_resp_err), 32'(e.err));
                    check("m0_rdata", m0_resp_rdata, e.rdata);
                    check("m0_latency", 32'(cyc - e.cyc), 32'd1);
                end
            end
            if (m1_resp_valid) begin
                n_resp1++;
                last_rdata1 = m1_resp_rdata;
                last_err1   = m1_resp_err;
                check("m1_resp_expected", 32'(q1.size() > 0), 32'd1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    check("m1_err", 32'(m1_resp_err), 32'(e.err));
                    check("m1_rdata", m1_resp_rdata, e.rdata);
                    check("m1_latency", 32'(cyc - e.cyc), 32'd1);
                end
            end
            if (m0_req_valid || m1_req_valid) begin
                check("single_grant", 32'(m0_req_ready & m1_req_ready), 32'd0);
            end
            if (m0_req_valid && m0_req_ready) begin
                predict(m0_req_we, m0_req_size, m0_req_addr, m0_req_wdata, e);
                q0.push_back(e);
                glog.push_back(0);
            end
            if (m1_req_valid && m1_req_ready) begin
                predict(m1_req_we, m1_req_size, m1_req_addr, m1_req_wdata, e);
                q1.push_back(e);
                glog.push_back(1);
            end
        end
    end

    // ---------------- stimulus helpers (enter and leave at posedge + 1) ----------------
    task automatic set_req(input int p, input logic v, input logic we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            m0_req_valid = v; m0_req_we = we; m0_req_size = sz; m0_req_addr = a; m0_req_wdata = wd;
        end else begin
            m1_req_valid = v; m1_req_we = we; m1_req_size = sz; m1_req_addr = a; m1_req_wdata = wd;
        end
    endtask

    // Issue one request, hold until accepted, let its response be scored.
    task automatic do_req(input int p, input logic we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, output int k);
        logic rdy;
        set_req(p, 1'b1, we, sz, a, wd);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            rdy = (p == 0) ? m0_req_ready : m1_req_ready;
        end while (!rdy && k < 20);
        if (!rdy) check($sformatf("p%0d_ready_timeout", p), 32'(rdy), 32'd1);
        @(posedge clk); #1;
        set_req(p, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int k;
    int w0;
    int exp_g4 [4]  = '{0, 1, 0, 1};
    int exp_gl [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1};

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        set_req(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        m1_lock = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m0_resp_valid", 32'(m0_resp_valid), 32'd0);
        check("rst_m1_resp_valid", 32'(m1_resp_valid), 32'd0);
        check("rst_m0_resp_err", 32'(m0_resp_err), 32'd0);
        check("rst_m1_resp_err", 32'(m1_resp_err), 32'd0);
        check("rst_m0_rdata", m0_resp_rdata, 32'd0);
        check("rst_m1_rdata", m1_resp_rdata, 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Store then load a word on port 0.
        do_req(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, k);
        check("st_ready_same_cycle", 32'(k), 32'd1);
        do_req(0, 1'b0, 2'b10, 32'h10, 32'd0, k);
        check("ld_ready_same_cycle", 32'(k), 32'd1);
        check("ld_word_data", last_rdata0, 32'hDEADBEEF);
        check("ld_word_err", 32'(last_err0), 32'd0);

        // Sign extension of byte and half loads.
        do_req(0, 1'b1, 2'b10, 32'h20, 32'h11223344, k);
        do_req(0, 1'b1, 2'b00, 32'h21, 32'h00000080, k);
        do_req(0, 1'b0, 2'b00, 32'h21, 32'd0, k);
        check("ld_byte_sext", last_rdata0, 32'hFFFFFF80);
        do_req(1, 1'b0, 2'b01, 32'h20, 32'd0, k);
        check("ld_half_sext", last_rdata1, 32'hFFFF8044);

        // Contention straight after reset: strict alternation starting at port 0.
        do_reset();
        glog.delete();
        n_resp0 = 0;
        n_resp1 = 0;
        set_req(0, 1'b1, 1'b0, 2'b10, 32'h10, 32'd0);
        set_req(1, 1'b1, 1'b0, 2'b10, 32'h20, 32'd0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rr_grant_count", 32'(glog.size()), 32'd4);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            check($sformatf("rr_grant_%0d", i), 32'(glog[i]), 32'(exp_g4[i]));
        check("rr_resp_m0", 32'(n_resp0), 32'd2);
        check("rr_resp_m1", 32'(n_resp1), 32'd2);

        // Rejected accesses never reach the memory; an in-range word does.
        w0 = wr_cnt;
        do_req(0, 1'b1, 2'b01, 32'h03, 32'h00001234, k);
        check("err_half_03", 32'(last_err0), 32'd1);
        do_req(0, 1'b1, 2'b10, 32'hFE, 32'h55555555, k);
        check("err_word_FE", 32'(last_err0), 32'd1);
        do_req(0, 1'b1, 2'b11, 32'h40, 32'h66666666, k);
        check("err_size_11", 32'(last_err0), 32'd1);
        check("err_no_write", 32'(wr_cnt - w0), 32'd0);
        do_req(0, 1'b1, 2'b10, 32'hFC, 32'hA5A5A5A5, k);
        check("ok_word_FC_err", 32'(last_err0), 32'd0);
        check("ok_word_FC_write", 32'(wr_cnt - w0), 32'd1);
        do_req(1, 1'b0, 2'b10, 32'hFC, 32'd0, k);
        check("ld_word_FC", last_rdata1, 32'hA5A5A5A5);
        do_req(1, 1'b0, 2'b00, 32'h100, 32'd0, k);
        check("err_ld_range", 32'(last_err1), 32'd1);
        check("err_ld_rdata", last_rdata1, 32'd0);

        // Lock: eight port-1 grants, one forced port-0 grant, then port 1 again.
        glog.delete();
        m1_lock = 1'b1;
        set_req(1, 1'b1, 1'b0, 2'b10, 32'h20, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 2'b10, 32'h10, 32'd0);
        repeat (9) @(negedge clk);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        m1_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("lock_grant_count", 32'(glog.size()), 32'd10);
        for (int i = 0; i < 10 && i < glog.size(); i++)
            check($sformatf("lock_grant_%0d", i), 32'(glog[i]), 32'(exp_gl[i]));

        // Reset during a port-0 store handshake.
        do_req(0, 1'b0, 2'b10, 32'h10, 32'd0, k);
        w0 = wr_cnt;
        rst = 1'b1;
        set_req(0, 1'b1, 1'b1, 2'b10, 32'h40, 32'hCAFEF00D);
        @(negedge clk);
        check("rst_write_gated", 32'(mem_write), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        @(negedge clk);
        check("rst_resp_dropped", 32'(m0_resp_valid), 32'd0);
        check("rst_no_write", 32'(wr_cnt - w0), 32'd0);
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 2'b10, 32'h40, 32'd0);
        set_req(1, 1'b1, 1'b0, 2'b10, 32'h20, 32'd0);
        @(negedge clk);
        check("rst_first_grant_m0", 32'(m0_req_ready), 32'd1);
        check("rst_first_grant_m1", 32'(m1_req_ready), 32'd0);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("ld_after_rst_40", last_rdata0, 32'd0);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port byte-addressed data memory between the core load/store unit (port 0) and a DMA/debug requester (port 1).
- Uses a valid/ready request handshake with round-robin arbitration.
- Returns responses one cycle after acceptance, with read data registered.
- Rejects misaligned, out-of-range and illegal-size accesses with an error response; the memory is not touched.

Parameters:
- MEM_BYTES, 256, memory size in bytes; an access with addr + size_bytes > MEM_BYTES is out of range.
- LOCK_MAX, 8, maximum consecutive grants port 1 may hold under lock before a forced release.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- m0_req_valid / m1_req_valid  in  1  request valid.
- m0_req_ready / m1_req_ready  out  1  request accepted this cycle (combinational grant).
- m0_req_we / m1_req_we  in  1  1 = store, 0 = load.
- m0_req_size / m1_req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- m0_req_addr / m1_req_addr  in  32  byte address.
- m0_req_wdata / m1_req_wdata  in  32  store data, LSB-aligned.
- m1_lock  in  1  port 1 requests to keep the grant across consecutive requests.
- m0_resp_valid / m1_resp_valid  out  1  one-cycle response pulse.
- m0_resp_rdata / m1_resp_rdata  out  32  sign-extended load data; 0 for stores and errors.
- m0_resp_err / m1_resp_err  out  1  access rejected.
- mem_write  out  1  memory write strobe.
- mem_size  out  2  size to memory.
- mem_addr  out  32  address to memory.
- mem_wdata  out  32  write data to memory.
- mem_rdata  in  32  asynchronous read data from memory.

Behaviour:
- Reset:
  - All resp_valid, resp_err = 0; resp_rdata = 0.
  - last_grant = 1, so port 0 wins the first contention.
  - lock_cnt = 0; state = ARB.
  - mem_write = 0 whenever no grant is active.
- Arbitration, one grant per cycle:
  - If only one port is valid, that port is granted.
  - If both are valid, the port not in last_grant is granted.
  - last_grant updates on every grant.
  - req_ready is high only for the granted port; a transfer happens when valid & ready.
- Memory drive:
  - mem_addr, mem_size and mem_wdata are muxed from the granted port in the same cycle.
  - mem_write = granted & we & ~error. The memory therefore writes on the same clock edge that the handshake completes.
- Error check (combinational on the granted request). The access is an error if any of these holds:
  - size == 11;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr + bytes > MEM_BYTES, computed at 33-bit width so there is no wrap-around.
- Error handling:
  - An error still consumes the grant.
  - The response carries err = 1 and rdata = 0.
  - No memory write occurs.
- Response:
  - In cycle N+1 after acceptance in cycle N, the granted port's resp_valid = 1 for exactly one cycle.
  - resp_rdata is the value of mem_rdata sampled at the edge ending cycle N (for loads), otherwise 0.
  - Back-to-back acceptance yields back-to-back responses.
- Lock FSM:
  - ARB → LOCK1 when port 1 is granted with m1_lock = 1.
  - In LOCK1, port 1 has absolute priority; lock_cnt increments per port-1 grant.
  - LOCK1 → ARB when m1_lock = 0 or m1_req_valid = 0.
  - LOCK1 → FORCE when lock_cnt reaches LOCK_MAX.
  - FORCE lasts one cycle: port 1 is masked, port 0 is granted if valid, then the FSM returns to ARB and lock_cnt = 0.
- Reset mid-operation:
  - A pending response is dropped (resp_valid = 0 next cycle).
  - A write presented in the reset cycle is suppressed (mem_write gated by ~rst).
  - The FSM returns to ARB.
- Requester obligations:
  - A requester must hold its request stable until ready; a deasserted valid cancels cleanly.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Enabled:
  - Adds outputs perf_m0_stall and perf_m1_stall, 32 bits each.
  - Each counts cycles where that port's req_valid & ~req_ready.
  - Both reset to 0 and saturate at 0xFFFFFFFF.
- Disabled:
  - The ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg:
  - mem_size_e enum (SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10).
  - arb_state_e (ARB, LOCK1, FORCE).
  - Function size_bytes(mem_size_e) returning 1/2/4.
  - Shared with the memory and LSU.
- Sub-module dmem_access_check: purely combinational error check (size, addr → err), instantiated once on the granted request.

Test Plan:
- Single port 0, store word 0xDEADBEEF @0x10, then load word @0x10: ready same cycle, resp next cycle with rdata = 0xDEADBEEF, err = 0.
- Byte load sign extension: store byte 0x80 @0x21, load byte @0x21 → rdata = 0xFFFFFF80; load half @0x20 → 0xFFFF80xx, where xx is the prior byte at 0x20.
- Both ports valid for 4 cycles after reset: grants go 0, 1, 0, 1; each port receives exactly 2 responses.
- Errors, no memory write in each case:
  - half @0x03 → err;
  - word @0xFE → err;
  - size 11 → err;
  - word @0xFC with MEM_BYTES = 256 → ok.
- Lock: m1_lock = 1 with continuous port-1 requests and port 0 waiting:
  - port 1 gets LOCK_MAX = 8 consecutive grants;
  - port 0 is granted in cycle 9;
  - port 1 resumes afterwards.
- Reset asserted during a port-0 store handshake → mem_write = 0, no resp_valid next cycle, next contention goes to port 0.
